cmd_issue_queue: RTL and testbench
==================================

Name: cmd_issue_queue

Overview:
- Command FIFO and issue stage directly upstream of the NTT engine command port (cmd_valid/cmd_opcode/cmd_slot/cmd_dma_addr, engine_ready).
- Accepts packed 64-bit command words from the host/loader over a valid/ready handshake and buffers up to DEPTH commands.
- Issues commands to the engine one at a time, only when the engine reports ready.
- Handles NOP and HALT locally; neither is forwarded to the engine.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH).
- OP_HALT, 8'hFF, opcode that stops issue.
- OP_NOP, 8'h00, opcode dropped without issue.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command word offered.
- in_word  in  64  [63:56] opcode, [55:52] slot, [51:48] reserved (ignored), [47:0] DMA address.
- in_ready  out  1  queue can accept a word.
- flush  in  1  drop all queued commands.
- engine_ready  in  1  engine idle and able to take a command.
- cmd_valid  out  1  one-cycle issue strobe.
- cmd_opcode  out  8  issued opcode.
- cmd_slot  out  4  issued slot.
- cmd_dma_addr  out  48  issued DMA address.
- halted  out  1  HALT has been consumed; sticky.
- level  out  PTR_W+1  current occupancy, 0..DEPTH.
- issued_count  out  32  commands issued to the engine.

Behaviour:
- Reset (async assert, sync deassert use) clears every output to 0: in_ready=0 during reset and 1 from the first clock edge after release, cmd_valid=0, cmd_* fields=0, halted=0, level=0, issued_count=0, FIFO pointers=0, FSM=IDLE.
- Push: a word is accepted on a clock edge where in_valid && in_ready. in_ready = !full && !flush, computed from registered state.
  - When full, a push is refused even if a pop happens in the same cycle (no bypass).
- Reserved bits [51:48] are not stored.
- FSM states: IDLE, ISSUE, COOLDOWN, HALTED.
- IDLE:
  - If the FIFO is non-empty and the head opcode == OP_NOP: pop, stay in IDLE. No strobe, no count.
  - Else if non-empty and head == OP_HALT: pop, go to HALTED, set halted=1 at the same edge.
  - Else if non-empty and engine_ready=1: pop the head into the cmd_* registers, set cmd_valid=1, go to ISSUE.
  - Else remain in IDLE.
- ISSUE:
  - cmd_valid is high for exactly this one cycle. issued_count increments at the exiting edge (wraps at 2^32).
  - Go to COOLDOWN unconditionally. cmd_valid returns to 0.
- COOLDOWN: one fixed cycle ignoring engine_ready, so the engine has time to drop ready. Then go to IDLE.
- cmd_opcode/cmd_slot/cmd_dma_addr hold the last issued values until the next issue; they are never changed by NOP, HALT or flush.
- Latency: a word pushed at edge t, with an empty queue, IDLE state and engine_ready=1, produces cmd_valid high in cycle t+1..t+2. Minimum issue spacing is 3 cycles (IDLE, ISSUE, COOLDOWN).
- HALTED:
  - No further pops; pushes are still accepted until full.
  - Only reset leaves HALTED. flush empties the queue but does not clear halted.
- Flush:
  - Resets pointers and level to 0 at the edge. Takes priority over a push and a pop in the same cycle.
  - If flush coincides with an IDLE issue decision, the issue is suppressed: no strobe, no count.
  - A strobe already in ISSUE completes normally.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop, 0 on flush.
- Pointers wrap modulo DEPTH. Full and empty are derived from level: full when level==DEPTH, empty when level==0.
- Reset mid-operation: all state is abandoned immediately (async). A cmd_valid in flight drops without completing.

Decomposition:
- Shared package (ntt_pkg): opcode constants (OP_NOP, OP_HALT, and the engine opcodes), the command-word field offsets, and the packed struct for {opcode, slot, addr}.
- One sub-module: sync_fifo (DEPTH x 60-bit storage, push/pop/flush, level output). The FSM and issue registers stay in cmd_issue_queue.

Test Plan:
- Basic issue: push {op=8'h01, slot=3, addr=48'h1000} with engine_ready=1 -> cmd_valid exactly one cycle, one cycle after acceptance, with matching fields; issued_count=1; level returns to 0.
- Backpressure: push 8 words with engine_ready=0 -> level=8, in_ready=0, a 9th word is not accepted. Raise engine_ready -> 8 strobes in FIFO order, spaced exactly 3 cycles apart.
- NOP/HALT: push op 8'h02, 8'h00, 8'hFF, 8'h03 -> only 8'h02 issued, halted=1, 8'h03 remains queued (level=1), issued_count=1.
- Flush: queue 5 words with engine_ready=0 and assert flush together with in_valid -> level=0, that word is not stored, no cmd_valid afterwards, halted unchanged.
- Reset mid-issue: drop rst_n during the cycle cmd_valid=1 -> all outputs 0 immediately; after release in_ready=1, level=0, issued_count=0.
- Wrap: push and issue 20 commands with sequential addresses through DEPTH=8 -> all 20 issued in order with correct addresses, no duplicates or losses.

Source files
------------

// File: rtl/cmd_issue_queue_pkg.sv
// cmd_issue_queue_pkg: shared opcodes, command-word field offsets, command struct and issue FSM states
package cmd_issue_queue_pkg;
  localparam logic [7:0] OPC_NOP = 8'h00, OPC_NTT = 8'h01, OPC_INTT = 8'h02, OPC_LOAD = 8'h03, OPC_STORE = 8'h04, OPC_HALT = 8'hFF;
  localparam int OPC_LSB = 56, SLOT_LSB = 52, ADDR_LSB = 0;
  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] slot;
    logic [47:0] addr;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN, HALTED} state_t;
  function automatic cmd_t unpack_word(input logic [63:0] w);
    return '{opcode: w[OPC_LSB+:8], slot: w[SLOT_LSB+:4], addr: w[ADDR_LSB+:48]};
  endfunction
endpackage

// File: rtl/cmd_issue_queue_if.sv
// cmd_issue_queue_if: host push handshake (in_valid/in_word/in_ready/flush), engine port (engine_ready/cmd_*), status (halted/level/issued_count)
interface cmd_issue_queue_if #(parameter int PTR_W = 3);
  logic in_valid;
  logic [63:0] in_word;
  logic in_ready;
  logic flush;
  logic engine_ready;
  logic cmd_valid;
  logic [7:0] cmd_opcode;
  logic [3:0] cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic halted;
  logic [PTR_W:0] level;
  logic [31:0] issued_count;
  modport master (output in_valid, in_word, flush, engine_ready, input in_ready, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr, halted, level, issued_count);
  modport slave (input in_valid, in_word, flush, engine_ready, output in_ready, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr, halted, level, issued_count);
endinterface

// File: rtl/cmd_issue_queue_sync_fifo.sv
// sync_fifo: DEPTH x 60-bit command FIFO; ports clk/rst_n, push/pop/flush, din/dout, level/full/empty
module sync_fifo
  import cmd_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  cmd_t           din,
  output cmd_t           dout,
  output logic [PTR_W:0] level,
  output logic           full,
  output logic           empty
);
  cmd_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
  assign full = level == (PTR_W+1)'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/cmd_issue_queue.sv
// cmd_issue_queue: command FIFO + issue FSM feeding the NTT engine; ports clk, rst_n, bus (slave: host push, engine issue, status)
module cmd_issue_queue
  import cmd_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter logic [7:0] OP_HALT = OPC_HALT,
  parameter logic [7:0] OP_NOP = OPC_NOP
) (
  input logic clk,
  input logic rst_n,
  cmd_issue_queue_if.slave bus
);
  state_t state, nxt;
  cmd_t din, head, cmd_q;
  logic full, empty, ready_q, take, push, pop, issue, is_nop, is_halt;
  logic [31:0] count;
  assign din = unpack_word(bus.in_word);
  sync_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk, .rst_n, .push, .pop, .flush(bus.flush), .din, .dout(head), .level(bus.level), .full, .empty
  );
  assign is_nop = head.opcode == OP_NOP;
  assign is_halt = head.opcode == OP_HALT;
  // flush overrides every IDLE decision, including NOP/HALT consumption
  assign take = state == IDLE && !empty && !bus.flush;
  assign issue = take && !is_nop && !is_halt && bus.engine_ready;
  assign pop = take && (is_nop || is_halt || bus.engine_ready);
  // ready_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = ready_q && !full && !bus.flush;
  assign push = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == ISSUE ? COOLDOWN :
          state == COOLDOWN ? IDLE :
          state == HALTED ? HALTED :
          !take ? IDLE :
          is_halt ? HALTED :
          issue ? ISSUE : IDLE;
  always_comb begin
    bus.cmd_valid = state == ISSUE;
    bus.halted = state == HALTED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ready_q <= 1'b0;
      cmd_q <= '0;
      count <= '0;
    end else begin
      ready_q <= 1'b1;
      if (issue) cmd_q <= head;
      if (state == ISSUE) count <= count + 1'b1;
    end
  assign bus.cmd_opcode = cmd_q.opcode;
  assign bus.cmd_slot = cmd_q.slot;
  assign bus.cmd_dma_addr = cmd_q.addr;
  assign bus.issued_count = count;
endmodule

// File: tb/tb_cmd_issue_queue.sv
// tb_cmd_issue_queue: randomized self-checking bench for cmd_issue_queue against a command-list reference model
module tb_cmd_issue_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cmd_issue_queue_if #(.PTR_W(3)) bus ();
  cmd_issue_queue #(.DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int errors = 0;
  int checks = 0;
  bit rnd_ready = 1'b0;
  logic [59:0] got[$];
  int got_cyc[$];
  logic [63:0] words[$];
  logic [59:0] exp_q[$];
  bit exp_halt;
  int exp_rem;
  always @(negedge clk)
    if (rst_n && bus.cmd_valid) begin
      got.push_back({bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr});
      got_cyc.push_back(cyc);
    end

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [3:0] slot, input logic [47:0] addr);
    return {op, slot, 4'($urandom_range(1, 15)), addr};
  endfunction

  function automatic logic [59:0] strip(input logic [63:0] w);
    return {w[63:52], w[47:0]};
  endfunction

  // expected behaviour from the command list alone: NOPs vanish, issue stops at the first HALT, the rest stays queued
  task automatic model();
    exp_q.delete();
    exp_halt = 1'b0;
    exp_rem = 0;
    foreach (words[i]) begin
      if (exp_halt) exp_rem++;
      else if (words[i][63:56] == 8'hFF) exp_halt = 1'b1;
      else if (words[i][63:56] != 8'h00) exp_q.push_back(strip(words[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) bus.engine_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_word(input logic [63:0] w, output int t);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_word = w;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL push_timeout: waited %0d cycles, required < 100", n);
    end
    tick();
    t = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.flush = 1'b0;
    bus.engine_ready = 1'b0;
    rnd_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    got.delete();
    got_cyc.delete();
    words.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_word = '1;
    bus.flush = 1'b0;
    bus.engine_ready = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.cmd_valid, bus.halted, bus.level, bus.issued_count, bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got in_ready=%b cmd_valid=%b halted=%b level=%0d count=%0d op=%h, required all 0", bus.in_ready, bus.cmd_valid, bus.halted, bus.level, bus.issued_count, bus.cmd_opcode);
    end
    repeat (2) tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_held: got %b required 0", bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.level !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b level=%0d required 1/0", bus.in_ready, bus.level);
    end
  endtask

  task automatic test_basic();
    int t;
    logic [63:0] w;
    do_reset();
    bus.engine_ready = 1'b1;
    w = mk(8'h01, 4'd3, 48'h1000);
    push_word(w, t);
    repeat (8) tick();
    checks++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL basic_strobes: got %0d required 1", got.size());
    end else begin
      checks++;
      if (got_cyc[0] != t + 1) begin
        errors++;
        $display("FAIL basic_latency: strobe after edge %0d required %0d", got_cyc[0], t + 1);
      end
      checks++;
      if (got[0] !== strip(w)) begin
        errors++;
        $display("FAIL basic_fields: got %h required %h", got[0], strip(w));
      end
    end
    checks++;
    if (bus.issued_count !== 32'd1 || bus.level !== 4'd0 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got count=%0d level=%0d cmd_valid=%b required 1/0/0", bus.issued_count, bus.level, bus.cmd_valid);
    end
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      words.push_back(mk(8'($urandom_range(1, 254)), 4'($urandom), 48'($urandom)));
      push_word(words[i], t);
    end
    checks++;
    if (bus.level !== 4'd8 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got level=%0d in_ready=%b required 8/0", bus.level, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_word = mk(8'h04, 4'd1, 48'hDEAD);
    repeat (3) tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.level !== 4'd8) begin
      errors++;
      $display("FAIL bp_ninth_refused: got level=%0d required 8", bus.level);
    end
    bus.engine_ready = 1'b1;
    repeat (40) tick();
    model();
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d strobes required %0d", got.size(), exp_q.size());
    end else
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h required %h", i, got[i], exp_q[i]);
        end
        if (i > 0) begin
          checks++;
          if (got_cyc[i] - got_cyc[i-1] != 3) begin
            errors++;
            $display("FAIL bp_spacing[%0d]: got %0d cycles required 3", i, got_cyc[i] - got_cyc[i-1]);
          end
        end
      end
    checks++;
    if (bus.issued_count !== 32'd8 || bus.level !== 4'd0) begin
      errors++;
      $display("FAIL bp_final: got count=%0d level=%0d required 8/0", bus.issued_count, bus.level);
    end
  endtask

  task automatic test_nop_halt();
    int t;
    logic [7:0] ops [4] = '{8'h02, 8'h00, 8'hFF, 8'h03};
    do_reset();
    bus.engine_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      words.push_back(mk(ops[i], 4'(i), 48'h3000 + 48'(i)));
      push_word(words[i], t);
    end
    repeat (20) tick();
    model();
    checks++;
    if (got.size() != exp_q.size() || (got.size() > 0 && got[0] !== exp_q[0])) begin
      errors++;
      $display("FAIL nh_issued: got %0d strobes first=%h required %0d first=%h", got.size(), got.size() > 0 ? got[0] : 60'h0, exp_q.size(), exp_q[0]);
    end
    checks++;
    if (bus.halted !== exp_halt || bus.level !== 4'(exp_rem) || bus.issued_count !== 32'(exp_q.size())) begin
      errors++;
      $display("FAIL nh_status: got halted=%b level=%0d count=%0d required %b/%0d/%0d", bus.halted, bus.level, bus.issued_count, exp_halt, exp_rem, exp_q.size());
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nh_push_while_halted: got in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_flush();
    int t;
    do_reset();
    for (int i = 0; i < 5; i++) push_word(mk(8'h01, 4'(i), 48'(i)), t);
    checks++;
    if (bus.level !== 4'd5) begin
      errors++;
      $display("FAIL fl_level5: got %0d required 5", bus.level);
    end
    bus.in_valid = 1'b1;
    bus.in_word = mk(8'h02, 4'd9, 48'hBEEF);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fl_in_ready: got %b required 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.level !== 4'd0) begin
      errors++;
      $display("FAIL fl_level0: got %0d required 0", bus.level);
    end
    bus.engine_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (got.size() != 0 || bus.issued_count !== 32'd0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL fl_no_issue: got strobes=%0d count=%0d halted=%b required 0/0/0", got.size(), bus.issued_count, bus.halted);
    end
    push_word(mk(8'hFF, 4'd0, 48'h0), t);
    push_word(mk(8'h01, 4'd1, 48'h1), t);
    push_word(mk(8'h01, 4'd2, 48'h2), t);
    repeat (3) tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.level !== 4'd2) begin
      errors++;
      $display("FAIL fl_halt_setup: got halted=%b level=%0d required 1/2", bus.halted, bus.level);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.level !== 4'd0 || got.size() != 0) begin
      errors++;
      $display("FAIL fl_halt_kept: got halted=%b level=%0d strobes=%0d required 1/0/0", bus.halted, bus.level, got.size());
    end
  endtask

  task automatic test_reset_mid_issue();
    int t;
    int n = 0;
    do_reset();
    bus.engine_ready = 1'b1;
    push_word(mk(8'h03, 4'd7, 48'hABCDE), t);
    while (!bus.cmd_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_strobe_seen: got cmd_valid=%b required 1", bus.cmd_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.cmd_valid, bus.halted, bus.level, bus.issued_count, bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr} !== '0) begin
      errors++;
      $display("FAIL rm_async_clear: got cmd_valid=%b op=%h slot=%h addr=%h in_ready=%b required all 0", bus.cmd_valid, bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr, bus.in_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.level !== 4'd0 || bus.issued_count !== 32'd0 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_after_release: got in_ready=%b level=%0d count=%0d cmd_valid=%b required 1/0/0/0", bus.in_ready, bus.level, bus.issued_count, bus.cmd_valid);
    end
  endtask

  task automatic test_wrap();
    int t;
    int n = 0;
    do_reset();
    bus.engine_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      words.push_back(mk(8'($urandom_range(1, 254)), 4'(i), 48'h2000 + 48'(i)));
      push_word(words[i], t);
    end
    while (got.size() < 20 && n < 200) begin
      tick();
      n++;
    end
    repeat (4) tick();
    model();
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count: got %0d strobes required %0d", got.size(), exp_q.size());
    end else
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %h required %h", i, got[i], exp_q[i]);
        end
      end
    checks++;
    if (bus.issued_count !== 32'd20) begin
      errors++;
      $display("FAIL wrap_issued_count: got %0d required 20", bus.issued_count);
    end
  endtask

  task automatic test_random();
    int t;
    int after;
    int r;
    logic [7:0] op;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      rnd_ready = 1'b1;
      after = -1;
      for (int i = 0; i < $urandom_range(12, 24); i++) begin
        r = $urandom_range(0, 15);
        op = (r == 0 && after < 0) ? 8'hFF : (r < 3) ? 8'h00 : 8'($urandom_range(1, 254));
        if (op == 8'hFF) after = 0;
        else if (after >= 0) after++;
        if (after > 5) break;
        words.push_back(mk(op, 4'($urandom), 48'($urandom)));
        push_word(words[words.size()-1], t);
      end
      rnd_ready = 1'b0;
      bus.engine_ready = 1'b1;
      repeat (40) tick();
      model();
      checks++;
      if (got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_count: got %0d strobes required %0d", round, got.size(), exp_q.size());
      end else
        for (int i = 0; i < got.size(); i++) begin
          checks++;
          if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd%0d_order[%0d]: got %h required %h", round, i, got[i], exp_q[i]);
          end
        end
      checks++;
      if (bus.halted !== exp_halt || bus.level !== 4'(exp_rem) || bus.issued_count !== 32'(exp_q.size())) begin
        errors++;
        $display("FAIL rnd%0d_status: got halted=%b level=%0d count=%0d required %b/%0d/%0d", round, bus.halted, bus.level, bus.issued_count, exp_halt, exp_rem, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_nop_halt();
    test_flush();
    test_reset_mid_issue();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
